// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and write-back FSM state type
//
// Purpose : constants and types shared by the register-file wrapper and the
//           write-back buffer in front of its write port.
// Contents: DATA_W, REG_AW, NUM_REGS, rf_state_e {IDLE, ISSUE, GAP}.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } rf_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - write-back entry queue with youngest-match forwarding lookup
//
// Purpose : circular FIFO of {reg, data} write-back entries, plus two
//           combinational lookup ports that return the youngest queued value
//           for a register.
// Ports   : clk, rst_n       clock, asynchronous active-low reset
//           push/push_reg/push_data  enqueue (caller guarantees !full)
//           pop                      dequeue head (caller guarantees !empty)
//           head_*/next_*            oldest and second-oldest entries
//           count/full/empty         occupancy
//           lk_{a,b}_reg -> lk_{a,b}_hit, lk_{a,b}_data  forwarding lookups
module rf_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_AW-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [REG_AW-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic [REG_AW-1:0] next_reg,
    output logic [DATA_W-1:0] next_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    input  logic [REG_AW-1:0] lk_a_reg,
    output logic              lk_a_hit,
    output logic [DATA_W-1:0] lk_a_data,
    input  logic [REG_AW-1:0] lk_b_reg,
    output logic              lk_b_hit,
    output logic [DATA_W-1:0] lk_b_data
);

    logic [REG_AW-1:0] reg_q  [DEPTH];
    logic [REG_AW-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [AW-1:0]     next_ptr;

    always_comb begin
        reg_d    = reg_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            reg_d[wr_ptr_q]  = push_reg;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= reg_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign next_ptr  = rd_ptr_q + AW'(1);
    assign head_reg  = reg_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign next_reg  = reg_q[next_ptr];
    assign next_data = data_q[next_ptr];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [AW-1:0] idx;
        lk_a_hit  = 1'b0;
        lk_a_data = '0;
        lk_b_hit  = 1'b0;
        lk_b_data = '0;
        idx       = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if (CW'(k) < count_q) begin
                if (reg_q[idx] == lk_a_reg) begin
                    lk_a_hit  = 1'b1;
                    lk_a_data = data_q[idx];
                end
                if (reg_q[idx] == lk_b_reg) begin
                    lk_b_hit  = 1'b1;
                    lk_b_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - write-back buffer draining into the register-file write port
//
// Purpose : queues completed results and drains them one per two cycles as a
//           one-cycle rf_dec_en pulse followed by an idle cycle; forwards
//           pending values to the two read ports.
// Ports   : CLK, CLR (async active-low)
//           wr_valid/wr_ready/wr_reg/wr_data   producer side
//           rf_hold, rf_in, rf_dsel, rf_dec_en register-file write port
//           sa/sb -> fwd_{a,b}_hit, fwd_{a,b}_data  read-side forwarding
//           count, empty                        occupancy
module rf_write_buffer #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int REG_AW = rf_pkg::REG_AW,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [REG_AW-1:0]        wr_reg,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rf_hold,
    output logic [DATA_W-1:0]        rf_in,
    output logic [REG_AW-1:0]        rf_dsel,
    output logic                     rf_dec_en,
    input  logic [REG_AW-1:0]        sa,
    input  logic [REG_AW-1:0]        sb,
    output logic                     fwd_a_hit,
    output logic                     fwd_b_hit,
    output logic [DATA_W-1:0]        fwd_a_data,
    output logic [DATA_W-1:0]        fwd_b_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    import rf_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    rf_state_e         state_q, state_d;
    logic              rf_dec_en_q, rf_dec_en_d;
    logic [DATA_W-1:0] rf_in_q, rf_in_d;
    logic [REG_AW-1:0] rf_dsel_q, rf_dsel_d;

    logic              push, pop, full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [REG_AW-1:0] head_reg, next_reg;
    logic [DATA_W-1:0] head_data, next_data;

    assign push = wr_valid && !full;

    rf_wb_fifo #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (CLR),
        .push      (push),
        .push_reg  (wr_reg),
        .push_data (wr_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .next_reg  (next_reg),
        .next_data (next_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (fifo_empty),
        .lk_a_reg  (sa),
        .lk_a_hit  (fwd_a_hit),
        .lk_a_data (fwd_a_data),
        .lk_b_reg  (sb),
        .lk_b_hit  (fwd_b_hit),
        .lk_b_data (fwd_b_data)
    );

    // The head is popped only when leaving GAP, so it stays visible to
    // forwarding until the register file has latched it. A back-to-back
    // issue from GAP therefore loads the second-oldest entry.
    always_comb begin
        state_d     = state_q;
        rf_dec_en_d = 1'b0;
        rf_in_d     = rf_in_q;
        rf_dsel_d   = rf_dsel_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !rf_hold) begin
                    state_d     = ISSUE;
                    rf_dec_en_d = 1'b1;
                    rf_in_d     = head_data;
                    rf_dsel_d   = head_reg;
                end
            end
            ISSUE: begin
                state_d = GAP;
            end
            GAP: begin
                pop = 1'b1;
                if ((fifo_count > CW'(1)) && !rf_hold) begin
                    state_d     = ISSUE;
                    rf_dec_en_d = 1'b1;
                    rf_in_d     = next_data;
                    rf_dsel_d   = next_reg;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= IDLE;
            rf_dec_en_q <= 1'b0;
            rf_in_q     <= '0;
            rf_dsel_q   <= '0;
        end else begin
            state_q     <= state_d;
            rf_dec_en_q <= rf_dec_en_d;
            rf_in_q     <= rf_in_d;
            rf_dsel_q   <= rf_dsel_d;
        end
    end

    assign rf_dec_en = rf_dec_en_q;
    assign rf_in     = rf_in_q;
    assign rf_dsel   = rf_dsel_q;
    assign wr_ready  = !full;
    assign count     = fifo_count;
    assign empty     = fifo_empty;

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - scoreboard bench for rf_write_buffer
module tb_rf_write_buffer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_reg = '0;
    logic [31:0] wr_data = '0;
    logic        rf_hold = 1'b0;
    logic [31:0] rf_in;
    logic [3:0]  rf_dsel;
    logic        rf_dec_en;
    logic [3:0]  sa = '0;
    logic [3:0]  sb = '0;
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_a_data, fwd_b_data;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [35:0] exp_q [$];
    int          pulse_cyc [$];
    logic        prev_en = 1'b0;

    rf_write_buffer #(.DATA_W(32), .REG_AW(4), .DEPTH(4)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .rf_hold    (rf_hold),
        .rf_in      (rf_in),
        .rf_dsel    (rf_dsel),
        .rf_dec_en  (rf_dec_en),
        .sa         (sa),
        .sb         (sb),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .count      (count),
        .empty      (empty)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every enable pulse is compared against the oldest expected write.
    always @(negedge CLK) begin
        if (!CLR) begin
            prev_en = 1'b0;
        end else begin
            if (rf_dec_en) begin
                pulse_cyc.push_back(cyc);
                if (prev_en) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_width: rf_dec_en high two cycles in a row");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: dsel=%0d in=0x%08h with empty scoreboard", rf_dsel, rf_in);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("pulse_dsel", {28'd0, rf_dsel}, {28'd0, e[35:32]});
                    chk("pulse_in", rf_in, e[31:0]);
                end
            end
            prev_en = rf_dec_en;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [31:0] d);
        int n;
        n = 0;
        while (!wr_ready && n < 40) begin
            step();
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: wr_ready stuck low for reg %0d", r);
        end
        wr_valid = 1'b1;
        wr_reg   = r;
        wr_data  = d;
        exp_q.push_back({r, d});
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !empty) && n < 60) begin
            step();
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_count0"}, {29'd0, count}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while CLR is low.
        #12;
        chk("rst_wr_ready", {31'd0, wr_ready}, 1);
        chk("rst_dec_en", {31'd0, rf_dec_en}, 0);
        chk("rst_rf_in", rf_in, 0);
        chk("rst_rf_dsel", {28'd0, rf_dsel}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_hit_a", {31'd0, fwd_a_hit}, 0);
        chk("rst_hit_b", {31'd0, fwd_b_hit}, 0);
        chk("rst_data_a", fwd_a_data, 0);
        chk("rst_data_b", fwd_b_data, 0);
        step();
        CLR = 1'b1;
        step();

        // Single write.
        push(4'd5, 32'h0000_0307);
        chk("single_count1", {29'd0, count}, 1);
        step();
        chk("single_en_hi", {31'd0, rf_dec_en}, 1);
        step();
        chk("single_en_lo", {31'd0, rf_dec_en}, 0);
        step();
        chk("single_count_after", {29'd0, count}, 0);
        wait_drain("single");

        // Back-to-back: pulses every second cycle.
        pulse_cyc.delete();
        push(4'd15, 32'hFFFF_FFFF);
        push(4'd4,  32'h1400_0006);
        push(4'd11, 32'h1680_0005);
        wait_drain("b2b");
        chk("b2b_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            chk("b2b_gap1", pulse_cyc[1] - pulse_cyc[0], 2);
            chk("b2b_gap2", pulse_cyc[2] - pulse_cyc[1], 2);
        end

        // Full and wrap: hold the drain so the queue actually fills.
        rf_hold = 1'b1;
        push(4'd1, 32'h0000_1111);
        push(4'd2, 32'h0000_2222);
        push(4'd3, 32'h0000_3333);
        chk("full_ready_before", {31'd0, wr_ready}, 1);
        push(4'd6, 32'h0000_6666);
        chk("full_ready_low", {31'd0, wr_ready}, 0);
        chk("full_count4", {29'd0, count}, 4);
        wr_valid = 1'b1;
        wr_reg   = 4'd9;
        wr_data  = 32'hDEAD_BEEF;
        step();
        wr_valid = 1'b0;
        chk("full_ignored", {29'd0, count}, 4);
        rf_hold = 1'b0;
        push(4'd7, 32'h0000_7777);
        push(4'd8, 32'h0000_8888);
        wait_drain("wrap");

        // Forwarding: youngest match wins, head stays visible until its GAP pop.
        sa = 4'd4;
        sb = 4'd3;
        push(4'd4, 32'h0000_000A);
        chk("fwd_first_data", fwd_a_data, 32'h0000_000A);
        push(4'd4, 32'h0000_000B);
        chk("fwd_a_hit", {31'd0, fwd_a_hit}, 1);
        chk("fwd_a_data", fwd_a_data, 32'h0000_000B);
        chk("fwd_b_hit", {31'd0, fwd_b_hit}, 0);
        chk("fwd_b_data", fwd_b_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fwd_a_hold_hit", {31'd0, fwd_a_hit}, 1);
            chk("fwd_a_hold_data", fwd_a_data, 32'h0000_000B);
        end
        step();
        chk("fwd_a_dropped", {31'd0, fwd_a_hit}, 0);
        chk("fwd_a_dropped_data", fwd_a_data, 0);
        wait_drain("fwd");

        // rf_hold blocks issue; an issue already started completes.
        pulse_cyc.delete();
        rf_hold = 1'b1;
        push(4'd12, 32'hC0DE_0012);
        push(4'd13, 32'hC0DE_0013);
        for (int i = 0; i < 4; i++) step();
        chk("hold_count2", {29'd0, count}, 2);
        chk("hold_no_pulse", pulse_cyc.size(), 0);
        rf_hold = 1'b0;
        step();
        chk("hold_release_pulse", {31'd0, rf_dec_en}, 1);
        rf_hold = 1'b1;
        step();
        chk("hold_issue_done", {31'd0, rf_dec_en}, 0);
        for (int i = 0; i < 3; i++) step();
        chk("hold_count1", {29'd0, count}, 1);
        chk("hold_one_pulse", pulse_cyc.size(), 1);
        rf_hold = 1'b0;
        wait_drain("hold");

        // Reset mid-drain.
        pulse_cyc.delete();
        push(4'd10, 32'h0BAD_0010);
        step();
        chk("mid_issue", {31'd0, rf_dec_en}, 1);
        #2;
        CLR = 1'b0;
        #1;
        chk("mid_en_async", {31'd0, rf_dec_en}, 0);
        chk("mid_count0", {29'd0, count}, 0);
        chk("mid_dsel0", {28'd0, rf_dsel}, 0);
        exp_q.delete();
        step();
        CLR = 1'b1;
        pulse_cyc.delete();
        for (int i = 0; i < 5; i++) step();
        chk("mid_no_pulse", pulse_cyc.size(), 0);
        chk("mid_empty", {31'd0, empty}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
